// File: rtl/two_mode_timer_ctrl.sv
// -----------------------------------------------------------------------------
// two_mode_timer_ctrl
//
// Control core of the two-mode timer. Holds the IDLE/RUN/PAUSE/DONE state
// machine, the 10 ms prescaler and the binary display counters that feed the
// seven-segment encoder.
//   Mode 0 : stopwatch, seconds.centiseconds counting up, saturates at 99.99
//   Mode 1 : countdown, minutes:seconds counting down from a clamped preset
//
// Ports
//   Clk        in   system clock, rising edge
//   Reset      in   synchronous, active-high
//   StartStop  in   pulse: start / pause / resume
//   Clear      in   pulse: back to IDLE with the counts reloaded
//   ModeIn     in   requested mode, taken only while IDLE
//   LoadMin    in   [7:0] countdown preset minutes (clamped to 99)
//   LoadSec    in   [7:0] countdown preset seconds (clamped to 59)
//   Lap        in   pulse: display freeze toggle (only with TIMER_LAP_EN)
//   MSBBinary  out  [7:0] seconds (mode 0) or minutes (mode 1)
//   LSBBinary  out  [7:0] centiseconds (mode 0) or seconds (mode 1)
//   ModeSel    out  latched mode
//   Running    out  high only in RUN
//   Done       out  high only in DONE
//
// Build option
//   TIMER_LAP_EN : when defined, Lap freezes the displayed value in RUN while
//                  the internal counts keep going. Undefined: Lap is ignored.
// -----------------------------------------------------------------------------
module two_mode_timer_ctrl #(
  parameter int TICK_DIV = 500000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       StartStop,
  input  logic       Clear,
  input  logic       ModeIn,
  input  logic [7:0] LoadMin,
  input  logic [7:0] LoadSec,
  input  logic       Lap,
  output logic [7:0] MSBBinary,
  output logic [7:0] LSBBinary,
  output logic       ModeSel,
  output logic       Running,
  output logic       Done
);

  localparam int            PW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_DONE
  } state_t;

  function automatic logic [7:0] clamp8(input logic [7:0] v, input logic [7:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  state_t        r_state;
  logic [PW-1:0] r_presc;
  logic [6:0]    r_cs;
  logic [7:0]    r_msb;
  logic [7:0]    r_lsb;
  logic          r_mode;
  logic          r_run;
  logic          r_done;

  state_t        w_state_nxt;
  logic [PW-1:0] w_presc_nxt;
  logic [6:0]    w_cs_nxt;
  logic [7:0]    w_msb_nxt;
  logic [7:0]    w_lsb_nxt;
  logic          w_mode_nxt;
  logic          w_tick;
  logic          w_term;
  logic [7:0]    w_min_clamp;
  logic [7:0]    w_sec_clamp;

  assign w_min_clamp = clamp8(LoadMin, 8'd99);
  assign w_sec_clamp = clamp8(LoadSec, 8'd59);
  assign w_tick      = (r_state == ST_RUN) && (r_presc == PRESC_MAX);

  always_comb begin
    w_state_nxt = r_state;
    w_presc_nxt = r_presc;
    w_cs_nxt    = r_cs;
    w_msb_nxt   = r_msb;
    w_lsb_nxt   = r_lsb;
    w_mode_nxt  = r_mode;
    w_term      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // Counts continuously track the preset so the display shows it.
        w_mode_nxt  = ModeIn;
        w_msb_nxt   = ModeIn ? w_min_clamp : 8'd0;
        w_lsb_nxt   = ModeIn ? w_sec_clamp : 8'd0;
        w_cs_nxt    = 7'd0;
        w_presc_nxt = '0;
        if (StartStop) begin
          if (ModeIn && (w_min_clamp == 8'd0) && (w_sec_clamp == 8'd0))
            w_state_nxt = ST_DONE;
          else
            w_state_nxt = ST_RUN;
        end
      end

      ST_RUN: begin
        w_presc_nxt = w_tick ? '0 : r_presc + 1'b1;
        if (w_tick) begin
          if (!r_mode) begin
            if (r_lsb >= 8'd99) begin
              if (r_msb < 8'd99) begin
                w_lsb_nxt = 8'd0;
                w_msb_nxt = r_msb + 8'd1;
              end
            end else begin
              w_lsb_nxt = r_lsb + 8'd1;
            end
            w_term = (w_msb_nxt == 8'd99) && (w_lsb_nxt == 8'd99);
          end else begin
            // Internal centisecond counter; its wrap is one elapsed second.
            if (r_cs >= 7'd99) begin
              w_cs_nxt = 7'd0;
              if (r_lsb != 8'd0) begin
                w_lsb_nxt = r_lsb - 8'd1;
              end else if (r_msb != 8'd0) begin
                w_lsb_nxt = 8'd59;
                w_msb_nxt = r_msb - 8'd1;
              end
              w_term = (w_msb_nxt == 8'd0) && (w_lsb_nxt == 8'd0);
            end else begin
              w_cs_nxt = r_cs + 7'd1;
            end
          end
        end
        // Reaching the terminal count takes priority over a pause request.
        if (w_term)
          w_state_nxt = ST_DONE;
        else if (StartStop)
          w_state_nxt = ST_PAUSE;
      end

      ST_PAUSE: begin
        // Prescaler and counts hold, so resuming keeps the partial tick.
        if (StartStop)
          w_state_nxt = ST_RUN;
      end

      ST_DONE: begin
      end

      default: w_state_nxt = ST_IDLE;
    endcase

    // Clear beats StartStop; reload on the same edge using the latched mode
    // so ModeSel stays frozen until IDLE is actually entered.
    if (Clear && (r_state != ST_IDLE)) begin
      w_state_nxt = ST_IDLE;
      w_msb_nxt   = r_mode ? w_min_clamp : 8'd0;
      w_lsb_nxt   = r_mode ? w_sec_clamp : 8'd0;
      w_cs_nxt    = 7'd0;
      w_presc_nxt = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_presc <= '0;
      r_cs    <= 7'd0;
      r_msb   <= 8'd0;
      r_lsb   <= 8'd0;
      r_mode  <= 1'b0;
      r_run   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_presc <= w_presc_nxt;
      r_cs    <= w_cs_nxt;
      r_msb   <= w_msb_nxt;
      r_lsb   <= w_lsb_nxt;
      r_mode  <= w_mode_nxt;
      r_run   <= (w_state_nxt == ST_RUN);
      r_done  <= (w_state_nxt == ST_DONE);
    end
  end

  assign ModeSel = r_mode;
  assign Running = r_run;
  assign Done    = r_done;

`ifdef TIMER_LAP_EN
  logic       r_frz;
  logic       w_frz_nxt;
  logic [7:0] r_dmsb;
  logic [7:0] r_dlsb;

  always_comb begin
    w_frz_nxt = r_frz;
    if ((r_state == ST_RUN) && Lap)
      w_frz_nxt = ~r_frz;
    // Entering DONE or IDLE always shows the real count.
    if ((w_state_nxt == ST_DONE) || (w_state_nxt == ST_IDLE))
      w_frz_nxt = 1'b0;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_frz  <= 1'b0;
      r_dmsb <= 8'd0;
      r_dlsb <= 8'd0;
    end else begin
      r_frz <= w_frz_nxt;
      if (!w_frz_nxt) begin
        r_dmsb <= w_msb_nxt;
        r_dlsb <= w_lsb_nxt;
      end
    end
  end

  assign MSBBinary = r_dmsb;
  assign LSBBinary = r_dlsb;
`else
  logic w_lap_unused;
  assign w_lap_unused = Lap;

  assign MSBBinary = r_msb;
  assign LSBBinary = r_lsb;
`endif

endmodule

// File: tb/tb_two_mode_timer_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for two_mode_timer_ctrl with TICK_DIV = 4.
// The stimulus process pushes the expected output snapshot, tagged with the
// cycle it applies to, into a queue; the monitor pops and compares on the
// falling edge of that cycle.
// -----------------------------------------------------------------------------
module tb_two_mode_timer_ctrl;

  localparam int TD = 4;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       StartStop = 1'b0;
  logic       Clear = 1'b0;
  logic       ModeIn = 1'b0;
  logic       Lap = 1'b0;
  logic [7:0] LoadMin = 8'd0;
  logic [7:0] LoadSec = 8'd0;
  logic [7:0] MSBBinary;
  logic [7:0] LSBBinary;
  logic       ModeSel;
  logic       Running;
  logic       Done;

  two_mode_timer_ctrl #(.TICK_DIV(TD)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .StartStop (StartStop),
    .Clear     (Clear),
    .ModeIn    (ModeIn),
    .LoadMin   (LoadMin),
    .LoadSec   (LoadSec),
    .Lap       (Lap),
    .MSBBinary (MSBBinary),
    .LSBBinary (LSBBinary),
    .ModeSel   (ModeSel),
    .Running   (Running),
    .Done      (Done)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    string      name;
    logic [7:0] msb;
    logic [7:0] lsb;
    logic       mode;
    logic       run;
    logic       done;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic exp_push(input string nm, input int m, input int l,
                          input logic md, input logic r, input logic d);
    exp_t e;
    e.at   = cyc;
    e.name = nm;
    e.msb  = 8'(m);
    e.lsb  = 8'(l);
    e.mode = md;
    e.run  = r;
    e.done = d;
    q.push_back(e);
  endtask

  task automatic check_now(input string nm, input int m, input int l,
                           input logic md, input logic r, input logic d);
    n_cmp++;
    if (MSBBinary !== 8'(m) || LSBBinary !== 8'(l) || ModeSel !== md ||
        Running !== r || Done !== d) begin
      n_bad++;
      $display("FAIL %s (cycle %0d, immediate): got msb=%0d lsb=%0d mode=%0b run=%0b done=%0b, want msb=%0d lsb=%0d mode=%0b run=%0b done=%0b",
               nm, cyc, MSBBinary, LSBBinary, ModeSel, Running, Done,
               m, l, md, r, d);
    end
  endtask

  task automatic pulse_ss();
    StartStop = 1'b1;
    step(1);
    StartStop = 1'b0;
  endtask

  task automatic pulse_clr();
    Clear = 1'b1;
    step(1);
    Clear = 1'b0;
  endtask

  task automatic pulse_lap();
    Lap = 1'b1;
    step(1);
    Lap = 1'b0;
  endtask

  // Monitor: compares every snapshot due in the current cycle.
  exp_t m_e;
  always @(negedge Clk) begin
    while (q.size() > 0 && q[0].at <= cyc) begin
      m_e = q.pop_front();
      n_cmp++;
      if (m_e.at != cyc || MSBBinary !== m_e.msb || LSBBinary !== m_e.lsb ||
          ModeSel !== m_e.mode || Running !== m_e.run || Done !== m_e.done) begin
        n_bad++;
        $display("FAIL %s (cycle %0d): got msb=%0d lsb=%0d mode=%0b run=%0b done=%0b, want msb=%0d lsb=%0d mode=%0b run=%0b done=%0b",
                 m_e.name, cyc, MSBBinary, LSBBinary, ModeSel, Running, Done,
                 m_e.msb, m_e.lsb, m_e.mode, m_e.run, m_e.done);
      end
    end
  end

  initial begin
    // Reset with busy inputs: outputs must still be all zero.
    ModeIn  = 1'b1;
    LoadMin = 8'd5;
    StartStop = 1'b1;
    step(3);
    exp_push("reset", 0, 0, 0, 0, 0);
    check_now("reset_now", 0, 0, 0, 0, 0);
    StartStop = 1'b0;
    ModeIn  = 1'b0;
    LoadMin = 8'd0;
    Reset   = 1'b0;
    step(1);
    exp_push("idle_sw", 0, 0, 0, 0, 0);

    // Stopwatch: 100 ticks = 1.00 s.
    pulse_ss();
    exp_push("sw_start", 0, 0, 0, 1, 0);
    step(400);
    exp_push("sw_1s", 1, 0, 0, 1, 0);

    // Pause on the 5th tick edge, hold, resume, one more tick.
    pulse_clr();
    exp_push("sw_clear", 0, 0, 0, 0, 0);
    pulse_ss();
    step(19);
    exp_push("sw_004", 0, 4, 0, 1, 0);
    pulse_ss();
    exp_push("pause_enter", 0, 5, 0, 0, 0);
    step(100);
    exp_push("pause_hold", 0, 5, 0, 0, 0);
    pulse_ss();
    exp_push("resume", 0, 5, 0, 1, 0);
    step(3);
    exp_push("resume_pre", 0, 5, 0, 1, 0);
    step(1);
    exp_push("resume_tick", 0, 6, 0, 1, 0);

    // Clear and StartStop together in RUN: Clear wins.
    Clear = 1'b1;
    StartStop = 1'b1;
    step(1);
    Clear = 1'b0;
    StartStop = 1'b0;
    exp_push("clr_ss", 0, 0, 0, 0, 0);
    step(1);
    exp_push("clr_ss_idle", 0, 0, 0, 0, 0);

    // Countdown from 1:00.
    ModeIn  = 1'b1;
    LoadMin = 8'd1;
    LoadSec = 8'd0;
    step(1);
    exp_push("cd_preset", 1, 0, 1, 0, 0);
    pulse_ss();
    exp_push("cd_start", 1, 0, 1, 1, 0);
    step(400);
    exp_push("cd_059", 0, 59, 1, 1, 0);
    step(23599);
    exp_push("cd_001", 0, 1, 1, 1, 0);
    step(1);
    exp_push("cd_done", 0, 0, 1, 0, 1);
    check_now("cd_expired_now", 0, 0, 1, 0, 1);
    pulse_ss();
    exp_push("done_ss_ign", 0, 0, 1, 0, 1);
    pulse_clr();
    exp_push("done_clear", 1, 0, 1, 0, 0);

    // Clamp and zero preset.
    LoadMin = 8'd150;
    LoadSec = 8'd75;
    step(1);
    exp_push("clamp", 99, 59, 1, 0, 0);
    LoadMin = 8'd0;
    LoadSec = 8'd0;
    step(1);
    exp_push("zero_preset", 0, 0, 1, 0, 0);
    pulse_ss();
    exp_push("zero_done", 0, 0, 1, 0, 1);
    pulse_clr();
    exp_push("zero_clear", 0, 0, 1, 0, 0);
    ModeIn = 1'b0;
    step(1);
    exp_push("mode_back", 0, 0, 0, 0, 0);

    // Stopwatch saturation at 99.99.
    pulse_ss();
    step(9998 * TD);
    exp_push("sw_9998", 99, 98, 0, 1, 0);
    step(TD);
    exp_push("sw_9999", 99, 99, 0, 0, 1);
    step(8);
    exp_push("sw_sat_hold", 99, 99, 0, 0, 1);

    // Lap: freeze at 00.10 for 40 cycles, then release.
    pulse_clr();
    exp_push("lap_clear", 0, 0, 0, 0, 0);
    pulse_ss();
    step(40);
    exp_push("lap_010", 0, 10, 0, 1, 0);
    pulse_lap();
    exp_push("lap_freeze", 0, 10, 0, 1, 0);
    step(39);
`ifdef TIMER_LAP_EN
    exp_push("lap_frozen", 0, 10, 0, 1, 0);
`else
    exp_push("lap_ignored", 0, 20, 0, 1, 0);
`endif
    pulse_lap();
    exp_push("lap_release", 0, 20, 0, 1, 0);

    // Reset mid-run.
    Reset = 1'b1;
    step(1);
    exp_push("reset_mid", 0, 0, 0, 0, 0);
    Reset = 1'b0;

    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/two_mode_timer_ctrl.md
# two_mode_timer_ctrl

Control core for the two-mode timer: an FSM plus prescaler and BCD-free binary counters that produce the 8-bit MSB/LSB values and the mode select consumed by the seven-segment encoder. Mode 0 is a stopwatch (seconds.centiseconds, counting up). Mode 1 is a countdown (minutes.seconds, counting down from a preset). It sits between the debounced button pulses and the display encoder.

## Interface
- TICK_DIV, 500000, clock cycles per 10 ms tick (100 Hz at 50 MHz); minimum 2
- Clk  in  1  system clock, all logic rising-edge
- Reset  in  1  synchronous, active-high
- StartStop  in  1  single-cycle pulse; start/pause/resume
- Clear  in  1  single-cycle pulse; return to IDLE and reload
- ModeIn  in  1  requested mode (0 stopwatch, 1 countdown); honoured only in IDLE
- LoadMin  in  8  countdown preset minutes; clamped to 99
- LoadSec  in  8  countdown preset seconds; clamped to 59
- Lap  in  1  single-cycle pulse; display freeze toggle (see Configuration)
- MSBBinary  out  8  upper display pair (mode 0: seconds 0..99; mode 1: minutes 0..99)
- LSBBinary  out  8  lower display pair (mode 0: centiseconds 0..99; mode 1: seconds 0..59)
- ModeSel  out  1  latched mode, drives encoder ModeSel
- Running  out  1  high only in RUN
- Done  out  1  high only in DONE

## Operation
- States: IDLE, RUN, PAUSE, DONE. Reset → IDLE.
- IDLE:
  - Each cycle, ModeSel ← ModeIn. Counts load 00.00 (mode 0) or the clamped preset (mode 1). The sub-second counter clears.
  - StartStop → RUN. If mode 1 and the preset is 00:00, StartStop → DONE instead.
- RUN:
  - StartStop → PAUSE.
  - The terminal condition → DONE.
- PAUSE: StartStop → RUN. The prescaler and all counts are held, so a resume keeps the partial tick.
- DONE: StartStop is ignored. Counts hold the terminal value.
- Clear in RUN, PAUSE or DONE → IDLE. Clear in IDLE has no effect beyond the normal reload.
- Clear and StartStop in the same cycle: Clear wins.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN and is cleared in IDLE.
  - A tick is asserted in the cycle where the count equals TICK_DIV-1; the count wraps to 0 on the same edge.
- Mode 0 on each tick:
  - LSB+1. At 99, LSB wraps to 0 and MSB+1.
  - At 99.99 the counts saturate and the state becomes DONE on the same edge.
- Mode 1:
  - An internal centisecond counter counts 0..99 on ticks. Its wrap is one second.
  - Each second: if LSB>0, LSB−1. Otherwise LSB←59 and MSB−1.
  - Reaching 00:00 sets DONE on that edge.
- Clamp rule: a value above its limit loads the limit (LoadMin 150 → 99). Arithmetic never leaves 0..99 / 0..59.
- ModeSel is frozen outside IDLE.

## Timing
- Reset values: MSBBinary=0, LSBBinary=0, ModeSel=0, Running=0, Done=0, prescaler=0, state IDLE.
- All outputs are registered.
- A StartStop sampled at edge N gives Running=1 after edge N. The first count change occurs TICK_DIV cycles later.
- The terminal count value and Done=1 appear after the same edge. Running drops on that edge.
- IDLE preset tracking has one cycle of latency from LoadMin/LoadSec/ModeIn to the outputs.
- Reset mid-operation overrides all inputs in that cycle. Outputs return to their reset values on the next edge.

## Configuration
- TIMER_LAP_EN defined:
  - In RUN, a Lap pulse freezes MSBBinary/LSBBinary at their current values while the internal counts continue. A second Lap pulse releases the freeze, and the outputs show the live count on the next edge.
  - The freeze is cleared by Clear, by Reset, and on entering DONE. On entering DONE the outputs show the terminal value.
  - Lap in states other than RUN is ignored.
- TIMER_LAP_EN undefined: the Lap port exists but is ignored, and the outputs always show the live count.

## Test plan
- TICK_DIV=4, ModeIn=0, pulse StartStop, wait 400 cycles → MSB=1, LSB=0, Running=1.
- Countdown: ModeIn=1, LoadMin=1, LoadSec=0. IDLE shows 1/0. Pulse StartStop; after 400 cycles → 0/59. After 24000 cycles total → 0/0, Done=1, Running=0.
- Pause: stopwatch at 00.05, pulse StartStop, wait 100 cycles → still 0/5 and Running=0. Resume; 4 cycles later → 0/6.
- Clear and StartStop in the same cycle during RUN → IDLE with 0/0. Clear during DONE → IDLE with the preset reloaded.
- Boundaries:
  - LoadMin=150, LoadSec=75 in mode 1 → 99/59.
  - Preset 00:00 with StartStop → Done=1 next cycle.
  - Stopwatch at 99.99 → Done=1, counts held at 99/99.
- TIMER_LAP_EN: Lap at 00.10, wait 40 cycles → outputs still 0/10. Second Lap → 0/20 next edge.
